fc_bus_arb: RTL
===============

FC_BUS_ARB -- requirements
Module: fc_bus_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, bus address width.
REQ-002 SHALL have parameter LEN_W, default 4, burst length field width (beats = len+1).
REQ-003 SHALL have parameter ID_W, default 4, transaction id width.
REQ-004 SHALL have parameter TIMEOUT, default 255, max idle cycles between data beats.
REQ-005 SHALL use one clock and a synchronous, active-low reset: clk, rst_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 rd_req_valid / rd_req_addr / rd_req_len / rd_req_id  input  1/ADDR_W/LEN_W/ID_W  read-address request from the read controller.
REQ-009 rd_req_ready  output  1  read request accepted this cycle.
REQ-010 wr_req_valid / wr_req_addr / wr_req_len / wr_req_id  input  1/ADDR_W/LEN_W/ID_W  write-address request from the write controller.
REQ-011 wr_req_ready  output  1  write request accepted this cycle.
REQ-012 bus_addr / bus_len / bus_id  output  ADDR_W/LEN_W/ID_W  shared address-phase fields.
REQ-013 bus_addr_valid  output  1; bus_addr_ready  input  1  address handshake.
REQ-014 bus_is_write  output  1  direction of the granted transfer.
REQ-015 rvalid, rlast  input  1 each  read data beat / last beat.
REQ-016 wready, wuser_last  input  1 each  write data beat accepted / last beat.
REQ-017 link_read, link_write  output  1 each  bus steering enables for the top-level tristate muxes.
REQ-018 timeout_err, len_err  output  1 each  single-cycle error pulses.

Function
REQ-019 FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA; all outputs registered, except rd_req_ready and wr_req_ready, which are combinational.
REQ-020 IDLE: exactly one valid -> grant it; both valid -> grant the side opposite last_grant; neither -> stay.
REQ-021 On grant, SHALL latch that requester's addr, len and id into bus fields, update last_grant, and enter X_ADDR next cycle (1-cycle grant latency).
REQ-022 X_ADDR: bus_addr_valid=1, fields stable until bus_addr_ready=1; X_req_ready = (state==X_ADDR && bus_addr_ready); next state X_DATA.
REQ-023 X_DATA: beat counter cleared on entry, increments on rvalid (read) or wready (write).
REQ-024 Data phase ends on the beat where count==len; if the last flag is also set, go to IDLE cleanly.
REQ-025 Last flag on a beat with count!=len, or count==len beat without last flag: SHALL end the phase, return to IDLE, pulse len_err.
REQ-026 Watchdog counts cycles with no beat in X_DATA; reaching TIMEOUT SHALL return to IDLE and pulse timeout_err.
REQ-027 link_read=1 iff state in {RD_ADDR, RD_DATA}; link_write=1 iff state in {WR_ADDR, WR_DATA}; never both.
REQ-028 bus_addr/bus_len/bus_id SHALL read 0 when bus_addr_valid=0.
REQ-029 A requester deasserting valid while in X_ADDR SHALL NOT abort the latched transfer.
REQ-030 Back-to-back: one IDLE cycle between the end of a data phase and the next X_ADDR.
REQ-031 Beats arriving in IDLE or X_ADDR SHALL be ignored.

Reset
REQ-032 On rst_n=0 at a clock edge: state=IDLE, last_grant=WR (read wins first tie), counters=0, all outputs 0; mid-transfer reset SHALL abort with no error pulse.

Structure
REQ-033 Package fc_bus_pkg SHALL hold the state enum, the grant-side enum and the default width constants.
REQ-034 Two-way round-robin grant logic SHALL be sub-module fc_rr_arb2 (inputs: two valids, last_grant; output: one-hot grant).

Verification
REQ-035 Read-only: rd_req addr=0x100, len=3; bus_addr_ready 1 cycle later; 4 rvalid with rlast on the 4th -> link_read high throughout, back to IDLE, no errors.
REQ-036 Simultaneous rd and wr requests from reset -> read granted first, write next, with exactly one IDLE cycle between.
REQ-037 Repeat simultaneous requests three times -> grants alternate RD, WR, RD.
REQ-038 Write len=3 with wuser_last on 2nd wready -> len_err pulse for 1 cycle, IDLE next cycle.
REQ-039 Read granted, no rvalid for 255 cycles -> timeout_err pulse, link_read drops.
REQ-040 rst_n low during WR_DATA -> next cycle all outputs 0, no error pulse, new read request granted normally.

Source files
------------

// File: rtl/fc_bus_pkg.sv
// Shared types and default widths for the read/write bus arbiter.
package fc_bus_pkg;

  localparam int unsigned DefAddrW   = 28;
  localparam int unsigned DefLenW    = 4;
  localparam int unsigned DefIdW     = 4;
  localparam int unsigned DefTimeout = 255;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrAddr,
    StWrData
  } arb_state_e;

  typedef enum logic {
    GntRd = 1'b0,
    GntWr = 1'b1
  } grant_side_e;

endpackage

// File: rtl/fc_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the side opposite last_grant wins.
module fc_rr_arb2
  import fc_bus_pkg::*;
(
  input  logic        rd_valid,
  input  logic        wr_valid,
  input  grant_side_e last_grant,
  output logic [1:0]  grant       // bit 0 = read, bit 1 = write
);

  always_comb begin
    grant = 2'b00;
    if (rd_valid && wr_valid) begin
      grant = (last_grant == GntWr) ? 2'b01 : 2'b10;
    end else if (rd_valid) begin
      grant = 2'b01;
    end else if (wr_valid) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/fc_bus_arb.sv
// Arbitrates read and write controllers onto one shared address/data bus,
// tracking burst length and a per-beat watchdog during the data phase.
module fc_bus_arb
  import fc_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned LEN_W   = DefLenW,
  parameter int unsigned ID_W    = DefIdW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_valid,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic [LEN_W-1:0]  rd_req_len,
  input  logic [ID_W-1:0]   rd_req_id,
  output logic              rd_req_ready,
  input  logic              wr_req_valid,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [LEN_W-1:0]  wr_req_len,
  input  logic [ID_W-1:0]   wr_req_id,
  output logic              wr_req_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [LEN_W-1:0]  bus_len,
  output logic [ID_W-1:0]   bus_id,
  output logic              bus_addr_valid,
  input  logic              bus_addr_ready,
  output logic              bus_is_write,
  input  logic              rvalid,
  input  logic              rlast,
  input  logic              wready,
  input  logic              wuser_last,
  output logic              link_read,
  output logic              link_write,
  output logic              timeout_err,
  output logic              len_err
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  arb_state_e       state_q;
  grant_side_e      last_grant_q;
  logic [LEN_W-1:0] xfer_len_q;
  logic [LEN_W-1:0] beat_cnt_q;
  logic [WdogW-1:0] wdog_q;
  logic [1:0]       grant;
  logic             beat;
  logic             beat_last;
  logic             len_done;

  fc_rr_arb2 u_rr_arb2 (
    .rd_valid   (rd_req_valid),
    .wr_valid   (wr_req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign rd_req_ready = (state_q == StRdAddr) && bus_addr_ready;
  assign wr_req_ready = (state_q == StWrAddr) && bus_addr_ready;

  // Only the beat signals of the active direction matter in a data phase.
  assign beat      = (state_q == StRdData) ? rvalid : wready;
  assign beat_last = (state_q == StRdData) ? rlast  : wuser_last;
  assign len_done  = (beat_cnt_q == xfer_len_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      last_grant_q   <= GntWr;
      xfer_len_q     <= '0;
      beat_cnt_q     <= '0;
      wdog_q         <= '0;
      bus_addr       <= '0;
      bus_len        <= '0;
      bus_id         <= '0;
      bus_addr_valid <= 1'b0;
      bus_is_write   <= 1'b0;
      link_read      <= 1'b0;
      link_write     <= 1'b0;
      timeout_err    <= 1'b0;
      len_err        <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      len_err     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant[0]) begin
            state_q        <= StRdAddr;
            last_grant_q   <= GntRd;
            bus_addr       <= rd_req_addr;
            bus_len        <= rd_req_len;
            bus_id         <= rd_req_id;
            xfer_len_q     <= rd_req_len;
            bus_addr_valid <= 1'b1;
            bus_is_write   <= 1'b0;
            link_read      <= 1'b1;
          end else if (grant[1]) begin
            state_q        <= StWrAddr;
            last_grant_q   <= GntWr;
            bus_addr       <= wr_req_addr;
            bus_len        <= wr_req_len;
            bus_id         <= wr_req_id;
            xfer_len_q     <= wr_req_len;
            bus_addr_valid <= 1'b1;
            bus_is_write   <= 1'b1;
            link_write     <= 1'b1;
          end
        end
        StRdAddr, StWrAddr: begin
          if (bus_addr_ready) begin
            state_q        <= (state_q == StRdAddr) ? StRdData : StWrData;
            bus_addr_valid <= 1'b0;
            bus_addr       <= '0;
            bus_len        <= '0;
            bus_id         <= '0;
            beat_cnt_q     <= '0;
            wdog_q         <= '0;
          end
        end
        StRdData, StWrData: begin
          if (beat) begin
            wdog_q <= '0;
            // Either the count or the last flag closes the burst; a mismatch is an error.
            if (len_done || beat_last) begin
              state_q      <= StIdle;
              link_read    <= 1'b0;
              link_write   <= 1'b0;
              bus_is_write <= 1'b0;
              len_err      <= !(len_done && beat_last);
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end else if (wdog_q == WdogW'(TIMEOUT - 1)) begin
            state_q      <= StIdle;
            link_read    <= 1'b0;
            link_write   <= 1'b0;
            bus_is_write <= 1'b0;
            timeout_err  <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
